// File: rtl/flit_injector_pkg.sv
// Shared types for the local-port flit injector: flit type encodings and FSM states.
package flit_injector_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD      = 2'b00,
    FLIT_BODY      = 2'b01,
    FLIT_TAIL      = 2'b10,
    FLIT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALLOC = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

endpackage

// File: rtl/flit_injector_vc_rr_select.sv
// Combinational round-robin pick: first eligible VC at or after the pointer, wrapping.
module vc_rr_select #(
  parameter int NUM_VCS = 4,
  parameter int VC_BITS = $clog2(NUM_VCS)
) (
  input  logic [NUM_VCS-1:0] elig_i,
  input  logic [VC_BITS-1:0] ptr_i,
  output logic               found_o,
  output logic [VC_BITS-1:0] vc_o
);

  logic [VC_BITS-1:0] cand;

  // Scan from the farthest offset down so the nearest eligible VC wins.
  always_comb begin
    found_o = 1'b0;
    vc_o    = '0;
    cand    = '0;
    for (int k = NUM_VCS - 1; k >= 0; k--) begin
      cand = VC_BITS'((int'(ptr_i) + k) % NUM_VCS);
      if (elig_i[cand]) begin
        found_o = 1'b1;
        vc_o    = cand;
      end
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Local-port transmit block: VC allocation, per-VC credit tracking and HEAD/BODY/TAIL flit emission.
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_ID_BITS = $clog2(NUM_ROUTERS),
  parameter int NUM_VCS        = 4,
  parameter int VC_BITS        = $clog2(NUM_VCS),
  parameter int BUFFER_DEPTH   = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_FLITS      = 8,
  parameter int LEN_BITS       = $clog2(MAX_FLITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ROUTER_ID_BITS-1:0] router_id,
  input  logic                      pkt_valid,
  output logic                      pkt_ready,
  input  logic [ROUTER_ID_BITS-1:0] pkt_dest,
  input  logic [LEN_BITS-1:0]       pkt_len,
  input  logic                      pld_valid,
  output logic                      pld_ready,
  input  logic [DATA_WIDTH-1:0]     pld_data,
  input  logic                      credit_valid,
  input  logic [VC_BITS-1:0]        credit_vc,
  output logic                      flit_valid,
  output logic [1:0]                flit_type,
  output logic [VC_BITS-1:0]        flit_vc,
  output logic [ROUTER_ID_BITS-1:0] flit_dest,
  output logic [ROUTER_ID_BITS-1:0] flit_src,
  output logic [DATA_WIDTH-1:0]     flit_data
);

  localparam int CRED_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUFFER_DEPTH);

  state_e                    state_q, state_d;
  logic                      run_q;
  logic [ROUTER_ID_BITS-1:0] dest_q, dest_d;
  logic [LEN_BITS-1:0]       len_q, len_d, idx_q, idx_d;
  logic [VC_BITS-1:0]        vc_q, vc_d, rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0]         credits_q [NUM_VCS];
  logic [NUM_VCS-1:0]        elig;
  logic                      found;
  logic [VC_BITS-1:0]        pick_vc;
  logic                      pld_fire, last_flit;
  flit_type_e                type_cur;

  logic                      flit_valid_q;
  flit_type_e                flit_type_q;
  logic [VC_BITS-1:0]        flit_vc_q;
  logic [ROUTER_ID_BITS-1:0] flit_dest_q, flit_src_q;
  logic [DATA_WIDTH-1:0]     flit_data_q;

  // Only a fully drained VC may start a new packet, so the previous tail has left the buffer.
  always_comb begin
    elig = '0;
    for (int v = 0; v < NUM_VCS; v++) elig[v] = (credits_q[v] == CRED_FULL);
  end

  vc_rr_select #(.NUM_VCS(NUM_VCS), .VC_BITS(VC_BITS)) u_rr (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .found_o(found),
    .vc_o   (pick_vc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      run_q    <= 1'b1;
    end
    dest_q <= dest_d;
    len_q  <= len_d;
    idx_q  <= idx_d;
    vc_q   <= vc_d;
  end

  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    len_d    = len_q;
    idx_d    = idx_q;
    vc_d     = vc_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: if (pkt_valid && pkt_ready) begin
        dest_d  = pkt_dest;
        len_d   = (pkt_len == '0) ? LEN_BITS'(1) : pkt_len;
        idx_d   = '0;
        state_d = ST_ALLOC;
      end
      ST_ALLOC: if (found) begin
        vc_d     = pick_vc;
        rr_ptr_d = VC_BITS'((int'(pick_vc) + 1) % NUM_VCS);
        state_d  = ST_SEND;
      end
      ST_SEND: if (pld_fire) begin
        idx_d = idx_q + LEN_BITS'(1);
        if (last_flit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // run_q keeps pkt_ready low through reset and releases it one cycle after rst_n rises.
  always_comb begin
    pkt_ready = run_q && (state_q == ST_IDLE);
    pld_ready = (state_q == ST_SEND) && (credits_q[vc_q] != '0);
    pld_fire  = pld_valid && pld_ready;
    last_flit = (idx_q == len_q - LEN_BITS'(1));
    if (len_q == LEN_BITS'(1))  type_cur = FLIT_HEAD_TAIL;
    else if (idx_q == '0)       type_cur = FLIT_HEAD;
    else if (last_flit)         type_cur = FLIT_TAIL;
    else                        type_cur = FLIT_BODY;
  end

  // A send and a return on the same VC in one cycle cancel out.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!rst_n) begin
        credits_q[v] <= CRED_FULL;
      end else if (credit_valid && (credit_vc == VC_BITS'(v)) &&
                   !(pld_fire && (vc_q == VC_BITS'(v)))) begin
        if (credits_q[v] != CRED_FULL) credits_q[v] <= credits_q[v] + CRED_W'(1);
      end else if (pld_fire && (vc_q == VC_BITS'(v)) &&
                   !(credit_valid && (credit_vc == VC_BITS'(v)))) begin
        credits_q[v] <= credits_q[v] - CRED_W'(1);
      end
    end
  end

  credit_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(credit_valid && (credits_q[credit_vc] == CRED_FULL) &&
      !(pld_fire && (vc_q == credit_vc))));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flit_valid_q <= 1'b0;
      flit_type_q  <= FLIT_HEAD;
      flit_vc_q    <= '0;
      flit_dest_q  <= '0;
      flit_src_q   <= '0;
      flit_data_q  <= '0;
    end else begin
      flit_valid_q <= pld_fire;
      if (pld_fire) begin
        flit_type_q <= type_cur;
        flit_vc_q   <= vc_q;
        flit_dest_q <= dest_q;
        flit_src_q  <= router_id;
        flit_data_q <= pld_data;
      end
    end
  end

  assign flit_valid = flit_valid_q;
  assign flit_type  = flit_type_q;
  assign flit_vc    = flit_vc_q;
  assign flit_dest  = flit_dest_q;
  assign flit_src   = flit_src_q;
  assign flit_data  = flit_data_q;

endmodule

// File: tb/tb_flit_injector.sv
// Scoreboard bench for flit_injector: expected flits queued at each payload handshake, checked on output.
module tb_flit_injector;

  localparam int RB = 4;
  localparam int VB = 2;
  localparam int LB = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    t;
    logic [VB-1:0] vc;
    logic [RB-1:0] dest;
    logic [RB-1:0] src;
    logic [DW-1:0] data;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RB-1:0] router_id;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [RB-1:0] pkt_dest;
  logic [LB-1:0] pkt_len;
  logic          pld_valid;
  logic          pld_ready;
  logic [DW-1:0] pld_data;
  logic          credit_valid;
  logic [VB-1:0] credit_vc;
  logic          flit_valid;
  logic [1:0]    flit_type;
  logic [VB-1:0] flit_vc;
  logic [RB-1:0] flit_dest;
  logic [RB-1:0] flit_src;
  logic [DW-1:0] flit_data;

  flit_t sb_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    nflits = 0;
  int    last_flit_cyc = -1;
  int    acc, acc_bg, n0;
  bit    drv_done;

  flit_injector dut (
    .clk(clk), .rst_n(rst_n), .router_id(router_id),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest), .pkt_len(pkt_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .flit_valid(flit_valid), .flit_type(flit_type), .flit_vc(flit_vc),
    .flit_dest(flit_dest), .flit_src(flit_src), .flit_data(flit_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (flit_valid) begin
      nflits        <= nflits + 1;
      last_flit_cyc <= cyc;
      if (sb_q.size() == 0) chk("unexpected_flit", {flit_type, flit_vc, flit_dest, flit_src, flit_data}, 64'd0);
      else chk("flit", {flit_type, flit_vc, flit_dest, flit_src, flit_data}, sb_q.pop_front());
    end
  end

  function automatic logic [1:0] exp_type(input int i, input int nf);
    if (nf == 1) return 2'b11;
    if (i == 0) return 2'b00;
    if (i == nf - 1) return 2'b10;
    return 2'b01;
  endfunction

  // Called at a falling edge; returns at the falling edge after the last payload handshake.
  task automatic send_pkt(input logic [RB-1:0] dest, input logic [LB-1:0] len, input logic [DW-1:0] base,
                          input logic [VB-1:0] evc, input bit cred_last, output int acc_o);
    int    nf;
    int    budget;
    flit_t e;
    nf    = (len == 0) ? 1 : int'(len);
    acc_o = -1;
    pkt_valid = 1'b1; pkt_dest = dest; pkt_len = len;
    budget = 0;
    while (!pkt_ready && budget < 60) begin @(negedge clk); budget++; end
    if (!pkt_ready) begin
      chk("pkt_accept_timeout", 64'd0, 64'd1);
      pkt_valid = 1'b0;
      return;
    end
    acc_o = cyc + 1;
    @(negedge clk);
    pkt_valid = 1'b0;
    for (int i = 0; i < nf; i++) begin
      pld_valid = 1'b1;
      pld_data  = base + DW'(i);
      budget = 0;
      while (!pld_ready && budget < 60) begin @(negedge clk); budget++; end
      if (!pld_ready) begin
        chk("pld_timeout", 64'd0, 64'd1);
        pld_valid = 1'b0;
        return;
      end
      e.t = exp_type(i, nf); e.vc = evc; e.dest = dest; e.src = router_id; e.data = base + DW'(i);
      sb_q.push_back(e);
      if (cred_last && i == nf - 1) begin credit_valid = 1'b1; credit_vc = '0; end
      @(negedge clk);
      credit_valid = 1'b0;
    end
    pld_valid = 1'b0;
  endtask

  task automatic credit_pulse(input logic [VB-1:0] v);
    credit_valid = 1'b1; credit_vc = v;
    @(negedge clk);
    credit_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pkt_valid = 1'b0; pld_valid = 1'b0; credit_valid = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_flits(input int target);
    int budget;
    budget = 0;
    while (nflits < target && budget < 60) begin @(negedge clk); budget++; end
    if (nflits < target) chk("flit_wait_timeout", 64'(nflits), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; router_id = '0; pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0;
    pld_valid = 1'b0; pld_data = '0; credit_valid = 1'b0; credit_vc = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready), 64'd0);
    chk("rst_flit_valid", 64'(flit_valid), 64'd0);
    chk("rst_credit0", 64'(dut.credits_q[0]), 64'd4);
    rst_n = 1'b1;
    @(negedge clk);
    chk("pkt_ready_after_rst", 64'(pkt_ready), 64'd1);

    // single-flit packet, minimum latency
    send_pkt(4'd5, 4'd1, 32'hA5, 2'd0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("latency_T3", 64'(last_flit_cyc - acc), 64'd2);
    chk("credit0_after_1", 64'(dut.credits_q[0]), 64'd3);

    // four-flit packet at full rate
    router_id = 4'd3;
    do_reset();
    n0 = nflits;
    send_pkt(4'd9, 4'd4, 32'd1, 2'd0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("burst_last_cyc", 64'(last_flit_cyc - acc), 64'd5);
    chk("burst_count", 64'(nflits - n0), 64'd4);
    chk("credit0_after_4", 64'(dut.credits_q[0]), 64'd0);

    // six-flit packet throttled by credits
    do_reset();
    n0 = nflits; drv_done = 1'b0;
    fork
      begin send_pkt(4'd2, 4'd6, 32'h100, 2'd0, 1'b0, acc_bg); drv_done = 1'b1; end
    join_none
    wait_flits(n0 + 4);
    repeat (3) @(negedge clk);
    chk("stall_pld_ready", 64'(pld_ready), 64'd0);
    chk("stall_count", 64'(nflits - n0), 64'd4);
    credit_pulse(2'd0);
    repeat (4) @(negedge clk);
    chk("one_credit_one_flit", 64'(nflits - n0), 64'd5);
    chk("stall2_pld_ready", 64'(pld_ready), 64'd0);
    credit_pulse(2'd0);
    for (int i = 0; i < 20 && !drv_done; i++) @(negedge clk);
    chk("six_done", 64'(drv_done), 64'd1);
    repeat (2) @(negedge clk);
    chk("six_count", 64'(nflits - n0), 64'd6);

    // round-robin across VCs, then hold in ALLOC with nothing eligible
    do_reset();
    send_pkt(4'd1, 4'd1, 32'h10, 2'd0, 1'b0, acc);
    send_pkt(4'd1, 4'd1, 32'h11, 2'd1, 1'b0, acc);
    send_pkt(4'd1, 4'd1, 32'h12, 2'd2, 1'b0, acc);
    send_pkt(4'd1, 4'd1, 32'h13, 2'd3, 1'b0, acc);
    repeat (2) @(negedge clk);
    n0 = nflits; drv_done = 1'b0;
    fork
      begin send_pkt(4'd7, 4'd2, 32'h20, 2'd2, 1'b0, acc_bg); drv_done = 1'b1; end
    join_none
    repeat (6) @(negedge clk);
    chk("alloc_hold_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("alloc_hold_pld_ready", 64'(pld_ready), 64'd0);
    chk("alloc_hold_no_flit", 64'(nflits - n0), 64'd0);
    credit_pulse(2'd2);
    for (int i = 0; i < 20 && !drv_done; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("alloc_release_count", 64'(nflits - n0), 64'd2);
    chk("credit2_after", 64'(dut.credits_q[2]), 64'd2);

    // credit and send on the same VC in one cycle; zero length; self-addressed
    do_reset();
    send_pkt(4'd6, 4'd2, 32'h30, 2'd0, 1'b1, acc);
    repeat (2) @(negedge clk);
    chk("same_cycle_credit0", 64'(dut.credits_q[0]), 64'd3);
    send_pkt(router_id, 4'd0, 32'h40, 2'd1, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("len0_credit1", 64'(dut.credits_q[1]), 64'd3);

    // reset in the middle of a five-flit packet
    do_reset();
    pkt_valid = 1'b1; pkt_dest = 4'd4; pkt_len = 4'd5;
    for (int i = 0; i < 10 && !pkt_ready; i++) @(negedge clk);
    @(negedge clk);
    pkt_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flit_t e;
      pld_valid = 1'b1; pld_data = 32'h50 + DW'(k);
      for (int i = 0; i < 10 && !pld_ready; i++) @(negedge clk);
      e.t = (k == 0) ? 2'b00 : 2'b01; e.vc = 2'd0; e.dest = 4'd4; e.src = router_id; e.data = 32'h50 + DW'(k);
      sb_q.push_back(e);
      @(negedge clk);
    end
    rst_n = 1'b0; pld_valid = 1'b0;
    @(negedge clk);
    chk("midrst_flit_valid", 64'(flit_valid), 64'd0);
    chk("midrst_pkt_ready", 64'(pkt_ready), 64'd0);
    chk("midrst_pld_ready", 64'(pld_ready), 64'd0);
    for (int v = 0; v < 4; v++) chk("midrst_credit", 64'(dut.credits_q[v]), 64'd4);
    chk("midrst_sb_empty", 64'(sb_q.size()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_pkt_ready_release", 64'(pkt_ready), 64'd1);

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
